wishbone_to_axi4lite: RTL and testbench

Wishbone classic slave to AXI4-Lite master bridge. It converts single Wishbone read/write cycles from a Wishbone-native core into AXI4-Lite transactions toward AXI-Lite peripherals and memories in the processor test harness. One outstanding transaction at a time. All outputs are registered.

---
 rtl/wishbone_to_axi4lite.sv | 160 ++++++++++++++++
 tb/tb_wishbone_to_axi4lite.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_to_axi4lite.sv
// Wishbone classic slave to AXI4-Lite master bridge, one transaction in flight.
// Every output except the constant PROT fields comes straight from a flop.
module wishbone_to_axi4lite #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,

    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,

    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,

    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                ARPROT,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t state_reg;

    logic accept;
    logic aw_done;
    logic w_done;

    assign AWPROT = PROT;
    assign ARPROT = PROT;

    // The ack/err guard keeps a strobe still held in the completion cycle
    // from being taken as a second request.
    assign accept  = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;

    // A channel counts as done once its VALID has dropped or is handshaking now.
    assign aw_done = !AWVALID || AWREADY;
    assign w_done  = !WVALID  || WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_reg <= IDLE;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (wb_we_i) begin
                            AWADDR    <= wb_adr_i;
                            WDATA     <= wb_dat_i;
                            WSTRB     <= wb_sel_i;
                            AWVALID   <= 1'b1;
                            WVALID    <= 1'b1;
                            state_reg <= WR_REQ;
                        end else begin
                            ARADDR    <= wb_adr_i;
                            ARVALID   <= 1'b1;
                            state_reg <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (AWVALID && AWREADY) begin
                        AWVALID <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        WVALID <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        BREADY    <= 1'b1;
                        state_reg <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        state_reg <= IDLE;
                        // An aborted Wishbone cycle still drains the AXI side silently.
                        if (wb_cyc_i) begin
                            wb_ack_o <= (BRESP == 2'b00);
                            wb_err_o <= (BRESP != 2'b00);
                        end
                    end
                end

                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID   <= 1'b0;
                        RREADY    <= 1'b1;
                        state_reg <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        wb_dat_o  <= RDATA;
                        state_reg <= IDLE;
                        if (wb_cyc_i) begin
                            wb_ack_o <= (RRESP == 2'b00);
                            wb_err_o <= (RRESP != 2'b00);
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_to_axi4lite.sv
// Bench for wishbone_to_axi4lite: Wishbone master driver, AXI-Lite slave model
// with per-channel delays, and a scoreboard monitor fed by expectation queues.
module tb_wishbone_to_axi4lite;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] awaddr, wdata, araddr, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;

    always #5 aclk = ~aclk;

    wishbone_to_axi4lite dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready)
    );

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } resp_t;

    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    resp_t       resp_q[$];

    int checks = 0;
    int errors = 0;
    int aw_hs  = 0;
    int r_hs   = 0;

    // Slave model configuration, changed by the stimulus between transactions.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // AXI-Lite slave: READY after a programmable wait, B/R after both/one request handshakes.
    initial begin : axi_slave
        bit hs_aw, hs_w, hs_ar, hs_b, hs_r, rst;
        bit aw_got, w_got, ar_got;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge aclk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_ar = arvalid && arready;
            hs_b  = bvalid && bready;
            hs_r  = rvalid && rready;
            rst   = !aresetn;
            @(posedge aclk);
            #1;
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            end else begin
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got = 1;
                if (hs_ar) ar_got = 1;
                if (hs_b) begin aw_got = 0; w_got = 0; bvalid = 0; b_cnt = 0; end
                if (hs_r) begin ar_got = 0; rvalid = 0; r_cnt = 0; end

                if (awvalid) begin
                    if (aw_cnt >= aw_delay) awready = 1; else begin awready = 0; aw_cnt++; end
                end else begin awready = 0; aw_cnt = 0; end
                if (wvalid) begin
                    if (w_cnt >= w_delay) wready = 1; else begin wready = 0; w_cnt++; end
                end else begin wready = 0; w_cnt = 0; end
                if (arvalid) begin
                    if (ar_cnt >= ar_delay) arready = 1; else begin arready = 0; ar_cnt++; end
                end else begin arready = 0; ar_cnt = 0; end

                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_cfg; end
                    else b_cnt++;
                end
                if (ar_got && !rvalid) begin
                    if (r_cnt >= r_delay) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
                    else r_cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations on every handshake and every Wishbone completion.
    initial begin : monitor
        bit          p_aw, p_w, p_ar, p_bready, aw_seen, w_seen;
        logic [31:0] pa_aw, pa_ar;
        logic [35:0] pa_w;
        resp_t       r;
        p_aw = 0; p_w = 0; p_ar = 0; p_bready = 0; aw_seen = 0; w_seen = 0;
        pa_aw = '0; pa_ar = '0; pa_w = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                p_aw = 0; p_w = 0; p_ar = 0; p_bready = 0; aw_seen = 0; w_seen = 0;
            end else begin
                if (p_aw) chk("awvalid_stable", {awvalid, awaddr}, {1'b1, pa_aw});
                if (p_w)  chk("wvalid_stable", {wvalid, wdata, wstrb}, {1'b1, pa_w});
                if (p_ar) chk("arvalid_stable", {arvalid, araddr}, {1'b1, pa_ar});
                if (bready && !p_bready) chk("bready_after_aw_and_w", {aw_seen, w_seen}, 2'b11);

                if (awvalid && awready) begin
                    aw_hs++;
                    aw_seen = 1;
                    if (aw_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL aw_unexpected: got addr %0h, required no AW handshake", awaddr);
                    end else chk("aw_addr_prot", {awaddr, awprot}, {aw_q.pop_front(), 3'b000});
                end
                if (wvalid && wready) begin
                    w_seen = 1;
                    if (w_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL w_unexpected: got data %0h, required no W handshake", wdata);
                    end else chk("w_data_strb", {wdata, wstrb}, w_q.pop_front());
                end
                if (arvalid && arready) begin
                    if (ar_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ar_unexpected: got addr %0h, required no AR handshake", araddr);
                    end else chk("ar_addr_prot", {araddr, arprot}, {ar_q.pop_front(), 3'b000});
                end
                if (bvalid && bready) begin aw_seen = 0; w_seen = 0; end
                if (rvalid && rready) r_hs++;

                if (wb_ack_o || wb_err_o) begin
                    if (resp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL wb_unexpected_completion: got ack=%0b err=%0b, required none",
                                 wb_ack_o, wb_err_o);
                    end else begin
                        r = resp_q.pop_front();
                        chk("wb_ack_err", {wb_ack_o, wb_err_o}, {!r.err, r.err});
                        if (r.rd) chk("wb_read_data", wb_dat_o, r.data);
                    end
                end

                p_aw = awvalid && !awready; pa_aw = awaddr;
                p_w  = wvalid && !wready;   pa_w  = {wdata, wstrb};
                p_ar = arvalid && !arready; pa_ar = araddr;
                p_bready = bready;
            end
        end
    end

    task automatic wb_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        @(posedge aclk);
        #1;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aclk);
            if (wb_ack_o || wb_err_o) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: got no ack/err within 200 cycles, required a completion", name);
        end
    endtask

    task automatic wb_end();
        @(posedge aclk);
        #1;
        wb_cyc = 0; wb_stb = 0;
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input bit err);
        resp_t r;
        r.err = err; r.rd = 0; r.data = '0;
        aw_q.push_back(adr);
        w_q.push_back({dat, sel});
        resp_q.push_back(r);
        wb_req(1, adr, dat, sel);
        wait_done("write_done");
        wb_end();
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [31:0] data, input bit err);
        resp_t r;
        r.err = err; r.rd = 1; r.data = data;
        rdata_cfg = data;
        ar_q.push_back(adr);
        resp_q.push_back(r);
        wb_req(0, adr, 32'h0, 4'h0);
        wait_done("read_done");
        wb_end();
    endtask

    initial begin : stimulus
        int r_before;
        bit seen;
        resp_t r;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_valid_ready_ack", {awvalid, wvalid, bready, arvalid, rready, wb_ack_o, wb_err_o}, 7'b0);
        chk("reset_payloads", {awaddr, wdata, wstrb, araddr}, 100'b0);
        chk("reset_wb_dat", wb_dat_o, 32'h0);
        @(posedge aclk);
        #1 aresetn = 1;

        // Immediate ready write
        do_write(32'h0000_0010, 32'hDEADBEEF, 4'hF, 0);

        // Skewed AW/W handshakes
        aw_delay = 1; w_delay = 4;
        do_write(32'h0000_0014, 32'hCAFEF00D, 4'h3, 0);
        aw_delay = 0; w_delay = 0;

        // Read with delayed AR and R
        ar_delay = 2; r_delay = 3;
        do_read(32'h0000_0020, 32'h12345678, 0);
        ar_delay = 0; r_delay = 0;

        // Error responses
        rresp_cfg = 2'b10;
        do_read(32'h0000_0024, 32'hA5A5_5A5A, 1);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        do_write(32'h0000_0028, 32'h0BAD_0BAD, 4'h8, 1);
        bresp_cfg = 2'b00;

        // Master abort during RD_RESP: AXI read completes, Wishbone sees nothing
        r_delay = 3;
        rdata_cfg = 32'h7777_0000;
        ar_q.push_back(32'h0000_002C);
        r_before = r_hs;
        wb_req(0, 32'h0000_002C, 32'h0, 4'h0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            if (rready) seen = 1;
        end
        chk("abort_rready_seen", seen, 1'b1);
        wb_end();
        for (int i = 0; i < 50 && rready; i++) @(negedge aclk);
        repeat (4) @(negedge aclk);
        chk("abort_r_handshake_count", r_hs - r_before, 1);
        r_delay = 0;

        // Reset in the middle of WR_REQ
        aw_delay = 8; w_delay = 8;
        wb_req(1, 32'h0000_0030, 32'h1111_2222, 4'hF);
        repeat (3) @(posedge aclk);
        #1;
        wb_cyc = 0; wb_stb = 0; aresetn = 0;
        @(posedge aclk);
        @(negedge aclk);
        chk("midreset_valid_ready_ack", {awvalid, wvalid, bready, arvalid, rready, wb_ack_o, wb_err_o}, 7'b0);
        chk("midreset_payloads", {awaddr, wdata, wstrb}, 68'b0);
        @(posedge aclk);
        #1 aresetn = 1;
        aw_delay = 0; w_delay = 0;
        do_write(32'h0000_0034, 32'h3333_4444, 4'hC, 0);

        // Back-to-back writes with stb held through the ack cycle
        r.err = 0; r.rd = 0; r.data = '0;
        aw_q.push_back(32'h0000_0040); w_q.push_back({32'h4040_4040, 4'hF}); resp_q.push_back(r);
        aw_q.push_back(32'h0000_0044); w_q.push_back({32'h4444_4444, 4'h1}); resp_q.push_back(r);
        wb_req(1, 32'h0000_0040, 32'h4040_4040, 4'hF);
        wait_done("b2b_first");
        @(posedge aclk);
        #1;
        wb_adr = 32'h0000_0044; wb_dat = 32'h4444_4444; wb_sel = 4'h1;
        wait_done("b2b_second");
        wb_end();

        repeat (10) @(negedge aclk);
        // Writes that complete: 0x10, 0x14, 0x28, 0x34, 0x40, 0x44
        chk("total_aw_handshakes", aw_hs, 6);
        chk("aw_queue_empty", aw_q.size(), 0);
        chk("w_queue_empty", w_q.size(), 0);
        chk("ar_queue_empty", ar_q.size(), 0);
        chk("resp_queue_empty", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
